// File: rtl/lab_mux_pkg.sv
// Shared constants for the lab board channel multiplexer.
// Holds the mode encodings, the scan FSM state encodings and a
// ceiling-log2 helper for tools that lack $clog2.
package lab_mux_pkg;

  // Mode pin encodings.
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Scan FSM state encodings, also visible on the debug output.
  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lab_mux_scan_sync2.sv
// Two-flop synchroniser for asynchronous board inputs.
// The whole vector is sampled together, so a multi-bit group must only be
// treated as coherent once the pins have been stable for a few clocks.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops; both clear on synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/lab_mux_scan.sv
// N-channel, W-bit registered multiplexer for the lab board.
// Manual mode routes the channel picked by sel; scan mode rotates through
// the channels round-robin, spending DWELL clocks on each. All pins are
// synchronised first, so a pin change reaches m three clocks later.
// The scan FSM state is a pure decode of the synchronised mode/hold pins
// and is exposed on dbg_state.
module lab_mux_scan
  import lab_mux_pkg::*;
#(
  parameter  int W     = 2,
  parameter  int N     = 4,
  parameter  int DWELL = 50_000_000,
  localparam int SW    = clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] din,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           hold,
  output logic [W-1:0]   m,
  output logic [SW-1:0]  ch,
  output logic           tick,
  output logic [1:0]     dbg_state
);

  // Dwell counter width; the counter never goes past DWELL-1.
  localparam int CW = clog2(DWELL);

  logic [N*W-1:0] w_din_s;
  logic [SW-1:0]  w_sel_s;
  logic           w_mode_s;
  logic           w_hold_s;

  logic [1:0]     w_state;
  logic           w_adv;
  logic [CW-1:0]  w_cnt_next;
  logic [SW-1:0]  w_ch_next;
  logic [W-1:0]   w_m_next;

  logic [W-1:0]   r_m;
  logic [SW-1:0]  r_ch;
  logic [CW-1:0]  r_cnt;
  logic           r_tick;

  sync2 #(.WIDTH(N*W)) u_sync_din  (.clk(clk), .rst_n(rst_n), .i_d(din),  .o_q(w_din_s));
  sync2 #(.WIDTH(SW))  u_sync_sel  (.clk(clk), .rst_n(rst_n), .i_d(sel),  .o_q(w_sel_s));
  sync2 #(.WIDTH(1))   u_sync_mode (.clk(clk), .rst_n(rst_n), .i_d(mode), .o_q(w_mode_s));
  sync2 #(.WIDTH(1))   u_sync_hold (.clk(clk), .rst_n(rst_n), .i_d(hold), .o_q(w_hold_s));

  // Scan FSM state decoded from the synchronised mode and hold pins.
  // Manual wins over hold, so leaving scan mode always clears the counter.
  always_comb begin
    w_state = ST_MANUAL;
    if (w_mode_s == MODE_SCAN) begin
      w_state = w_hold_s ? ST_HOLD : ST_SCAN;
    end
  end

  // Next counter / channel. An advance only happens while scanning, so a
  // tick due in the cycle manual mode takes over is dropped naturally.
  always_comb begin
    w_adv      = 1'b0;
    w_cnt_next = '0;
    w_ch_next  = r_ch;
    if (w_state == ST_MANUAL) begin
      w_cnt_next = '0;
      w_ch_next  = w_sel_s;
    end else if (w_state == ST_HOLD) begin
      w_cnt_next = r_cnt;
      w_ch_next  = r_ch;
    end else begin
      if (r_cnt == CW'(DWELL - 1)) begin
        w_adv      = 1'b1;
        w_cnt_next = '0;
        // An out-of-range channel left over from manual mode wraps to 0.
        w_ch_next  = (r_ch >= SW'(N - 1)) ? '0 : r_ch + SW'(1);
      end else begin
        w_cnt_next = r_cnt + CW'(1);
        w_ch_next  = r_ch;
      end
    end
  end

  // Output mux as a slice select; a channel number >= N yields zero.
  always_comb begin
    w_m_next = '0;
    for (int k = 0; k < N; k++) begin
      if (w_ch_next == SW'(k)) begin
        w_m_next = w_din_s[k*W +: W];
      end
    end
  end

  // Registered outputs and scan state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m    <= '0;
      r_ch   <= '0;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_m    <= w_m_next;
      r_ch   <= w_ch_next;
      r_cnt  <= w_cnt_next;
      r_tick <= w_adv;
    end
  end

  assign m         = r_m;
  assign ch        = r_ch;
  assign tick      = r_tick;
  assign dbg_state = w_state;

endmodule

// File: tb/tb_lab_mux_scan.sv
// Bench for lab_mux_scan: a 4-channel instance for reset, manual, scan,
// hold and mode-switch behaviour, and a 3-channel instance for the
// out-of-range select case. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_lab_mux_scan;
  import lab_mux_pkg::*;

  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic [7:0] din4;
  logic [1:0] sel4;
  logic       mode4, hold4;
  logic [1:0] m4, ch4, st4;
  logic       tick4;

  logic [5:0] din3;
  logic [1:0] sel3;
  logic       mode3, hold3;
  logic [1:0] m3, ch3, st3;
  logic       tick3;

  lab_mux_scan #(.W(2), .N(4), .DWELL(DW)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel4), .mode(mode4),
    .hold(hold4), .m(m4), .ch(ch4), .tick(tick4), .dbg_state(st4)
  );

  lab_mux_scan #(.W(2), .N(3), .DWELL(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .mode(mode3),
    .hold(hold3), .m(m3), .ch(ch3), .tick(tick3), .dbg_state(st3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard entries are {m, ch}.
  logic [3:0] exp_q[$];

  typedef struct {
    logic [1:0] sel;
    logic [7:0] din;
    logic [1:0] exp_m;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse reset for two clocks; returns on the release edge (cycle 0).
  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic sb_check(input string name, input logic [1:0] am, input logic [1:0] ach);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_m"}, am, e[3:2]);
      chk({name, "_ch"}, ach, e[1:0]);
    end
  endtask

  initial begin
    logic [7:0] tmp;
    logic [1:0] esel;
    int exp_ch;

    rst_n = 1'b0;
    din4 = 8'hFF; sel4 = 2'd0; mode4 = 1'b0; hold4 = 1'b0;
    din3 = 6'h3F; sel3 = 2'd0; mode3 = 1'b0; hold3 = 1'b0;

    // ---- Reset state and first-data latency ----
    step(2);
    chk("rst_m4", m4, 2'b00);
    chk("rst_ch4", ch4, 2'd0);
    chk("rst_tick4", tick4, 1'b0);
    chk("rst_m3", m3, 2'b00);
    chk("rst_ch3", ch3, 2'd0);
    rst_n = 1'b1;
    step(2);
    chk("lat_m_c2", m4, 2'b00);
    step(1);
    chk("lat_m_c3", m4, 2'b11);

    // ---- Manual mode vector table ----
    vecs[0] = '{2'd2, 8'hE4, 2'b10, 2'd2};
    vecs[1] = '{2'd0, 8'hE4, 2'b00, 2'd0};
    vecs[2] = '{2'd3, 8'hE4, 2'b11, 2'd3};
    vecs[3] = '{2'd1, 8'hE4, 2'b01, 2'd1};
    vecs[4] = '{2'd1, 8'h08, 2'b10, 2'd1};
    for (int i = 5; i < 10; i++) begin
      vecs[i].din = 8'($urandom_range(0, 255));
      vecs[i].sel = 2'($urandom_range(0, 3));
      tmp = vecs[i].din >> (2 * vecs[i].sel);
      vecs[i].exp_m  = tmp[1:0];
      vecs[i].exp_ch = vecs[i].sel;
    end
    for (int i = 0; i < 10; i++) begin
      sel4 = vecs[i].sel;
      din4 = vecs[i].din;
      exp_q.push_back({vecs[i].exp_m, vecs[i].exp_ch});
      for (int c = 0; c < 3; c++) begin
        step(1);
        chk($sformatf("man_tick_v%0d", i), tick4, 1'b0);
      end
      sb_check($sformatf("man_v%0d", i), m4, ch4);
    end

    // ---- Scan: channel steps every DWELL clocks, one-cycle tick ----
    din4 = 8'hE4; sel4 = 2'd0; mode4 = 1'b1; hold4 = 1'b0;
    do_reset();
    for (int i = 1; i <= 22; i++) begin
      step(1);
      exp_ch = (i < 6) ? 0 : (((i - 6) / 4 + 1) % 4);
      exp_q.push_back({2'(exp_ch), 2'(exp_ch)});
      sb_check($sformatf("scan_c%0d", i), m4, ch4);
      chk($sformatf("scan_tick_c%0d", i), tick4, (i >= 6 && ((i - 6) % 4) == 0) ? 1'b1 : 1'b0);
      if (i == 4) chk("scan_state", st4, ST_SCAN);
    end

    // ---- Hold: freeze at ch1, data still tracks, resume remaining dwell ----
    din4 = 8'hE4; sel4 = 2'd0; mode4 = 1'b1; hold4 = 1'b0;
    do_reset();
    step(6);
    chk("hold_pre_ch", ch4, 2'd1);
    chk("hold_pre_tick", tick4, 1'b1);
    hold4 = 1'b1;
    for (int i = 7; i <= 29; i++) begin
      step(1);
      chk($sformatf("hold_ch_c%0d", i), ch4, 2'd1);
      chk($sformatf("hold_tick_c%0d", i), tick4, 1'b0);
      if (i == 12) chk("hold_m_old", m4, 2'b01);
      if (i >= 13) chk($sformatf("hold_m_new_c%0d", i), m4, 2'b11);
      if (i == 20) chk("hold_state", st4, ST_HOLD);
      if (i == 10) din4 = 8'hEC;
      if (i == 26) hold4 = 1'b0;
    end
    step(1);
    chk("hold_resume_ch", ch4, 2'd2);
    chk("hold_resume_tick", tick4, 1'b1);
    chk("hold_resume_m", m4, 2'b10);

    // ---- Mode switch on the tick cycle, then back to scan ----
    din4 = 8'hE4; sel4 = 2'd3; mode4 = 1'b1; hold4 = 1'b0;
    do_reset();
    step(6);
    chk("ms_first_ch", ch4, 2'd1);
    step(1);
    mode4 = 1'b0;
    for (int i = 8; i <= 9; i++) begin
      step(1);
      chk($sformatf("ms_ch_c%0d", i), ch4, 2'd1);
      chk($sformatf("ms_tick_c%0d", i), tick4, 1'b0);
    end
    step(1);
    chk("ms_sw_ch", ch4, 2'd3);
    chk("ms_sw_tick", tick4, 1'b0);
    chk("ms_sw_m", m4, 2'b11);
    step(1);
    mode4 = 1'b1;
    for (int i = 12; i <= 16; i++) begin
      step(1);
      chk($sformatf("ms_back_ch_c%0d", i), ch4, 2'd3);
      chk($sformatf("ms_back_tick_c%0d", i), tick4, 1'b0);
    end
    step(1);
    chk("ms_back_adv_ch", ch4, 2'd0);
    chk("ms_back_adv_tick", tick4, 1'b1);
    chk("ms_back_adv_m", m4, 2'b00);

    // ---- N=3: out-of-range select, then scan wrap ----
    din3 = 6'b10_01_11; sel3 = 2'd3; mode3 = 1'b0; hold3 = 1'b0;
    mode4 = 1'b0;
    do_reset();
    step(3);
    chk("n3_oor_m", m3, 2'b00);
    chk("n3_oor_ch", ch3, 2'd3);
    mode3 = 1'b1;
    for (int i = 4; i <= 8; i++) begin
      step(1);
      chk($sformatf("n3_wait_ch_c%0d", i), ch3, 2'd3);
      chk($sformatf("n3_wait_tick_c%0d", i), tick3, 1'b0);
    end
    for (int s = 0; s < 4; s++) begin
      step(s == 0 ? 1 : 4);
      esel = 2'(s % 3);
      tmp  = {2'b00, din3} >> (2 * esel);
      chk($sformatf("n3_step%0d_ch", s), ch3, esel);
      chk($sformatf("n3_step%0d_m", s), m3, tmp[1:0]);
      chk($sformatf("n3_step%0d_tick", s), tick3, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
